// File: rtl/embertrail_fetch.sv
// embertrail_fetch: halfword fetch + prefetch queue building 16/32-bit packets (oIR/oPC) for the control unit.
// Latency: response in cycle N -> single-halfword packet valid in N+1; dual packet valid the cycle after its 2nd half.
// Backpressure: iIRReady low holds oIR/oPC stable; the queue fills to DEPTH and oMemReq stops until space frees.
//
// Optional feature: define EMBERTRAIL_FETCH_BYPASS_EN to present a single-halfword response
// arriving at an empty queue in the same cycle (combinational path iMemData -> oIR).
// Default build (macro undefined) keeps every output driven from registered state.
module embertrail_fetch #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        iClock,
    input  logic        iReset,
    output logic        oMemReq,
    output logic [15:0] oMemAddr,
    input  logic        iMemValid,
    input  logic [15:0] iMemData,
    input  logic        iRedirect,
    input  logic [15:0] iTarget,
    output logic        oIRValid,
    input  logic        iIRReady,
    output logic [31:0] oIR,
    output logic [15:0] oPC
);

    localparam int             PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             CW   = PW + 1;
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);

    // Queue storage and bookkeeping
    logic [15:0]   q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    // Fetch-side state
    logic [15:0]   fetchPC;
    logic [15:0]   headPC;
    logic          outstanding;
    logic          drop;

    // Packet view of the queue head
    logic [PW-1:0] headPlusOne;
    logic [15:0]   hw0;
    logic [15:0]   hw1;
    logic          dual;
    logic [CW-1:0] need;
    logic          queueValid;

    // Per-cycle control
    logic          bypassHit;
    logic          accept;
    logic          popQ;
    logic          bypassTake;
    logic          respOk;
    logic          push;
    logic [CW-1:0] popCnt;
    logic [CW-1:0] pushCnt;
    logic [15:0]   pcStep;

    assign headPlusOne = head + PW'(1);
    assign hw0         = q[head];
    assign hw1         = q[headPlusOne];
    assign dual        = hw0[15];
    assign need        = dual ? CW'(2) : CW'(1);
    // count == 0 always fails this test because need is at least 1, so stale
    // queue contents never leak out as a packet.
    assign queueValid  = (count >= need);

`ifdef EMBERTRAIL_FETCH_BYPASS_EN
    // A single-halfword response landing in an empty queue can be handed
    // straight to the consumer; the redirect cycle discards responses, so
    // the bypass is closed then too.
    assign bypassHit = !iReset && !iRedirect && (count == '0) && !drop
                       && iMemValid && !iMemData[15];
`else
    assign bypassHit = 1'b0;
`endif

    // Output packet: queue head first, bypass only when the queue has nothing
    always_comb begin
        oIRValid = 1'b0;
        oIR      = 32'h0;
        oPC      = headPC;
        if (!iReset && queueValid) begin
            oIRValid = 1'b1;
            oIR      = dual ? {hw1, hw0} : {16'h0, hw0};
        end else if (bypassHit) begin
            oIRValid = 1'b1;
            oIR      = {16'h0, iMemData};
        end
    end

    // Handshake decode: a redirect overrides any accept or response this cycle
    always_comb begin
        accept     = oIRValid && iIRReady && !iRedirect && !iReset;
        popQ       = accept && queueValid;
        bypassTake = accept && !queueValid && bypassHit;
        respOk     = iMemValid && !drop && !iRedirect && !iReset;
        push       = respOk && !bypassTake;
        popCnt     = popQ ? need : '0;
        pushCnt    = push ? CW'(1) : '0;
        pcStep     = (popQ && dual) ? 16'd2 : 16'd1;
    end

    // Request issue: one outstanding request, only while the queue has room
    assign oMemReq  = !iReset && !outstanding && (count < FULL) && !iRedirect;
    assign oMemAddr = fetchPC;

    // Queue data array; contents need no reset since count gates visibility
    always_ff @(posedge iClock) begin
        if (push) begin
            q[tail] <= iMemData;
        end
    end

    // Queue pointers and occupancy; a redirect flushes by collapsing head onto tail
    always_ff @(posedge iClock) begin
        if (iReset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (iRedirect) begin
            head  <= tail;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (popQ) begin
                head <= head + need[PW-1:0];
            end
            count <= count + pushCnt - popCnt;
        end
    end

    // Fetch/head addresses and the stale-response drop flag
    always_ff @(posedge iClock) begin
        if (iReset) begin
            fetchPC <= RESET_PC;
            headPC  <= RESET_PC;
            drop    <= 1'b0;
        end else if (iRedirect) begin
            fetchPC <= iTarget;
            headPC  <= iTarget;
            // A response arriving in this very cycle is discarded here, so
            // only a request still in flight afterwards needs dropping.
            drop    <= outstanding && !iMemValid;
        end else begin
            if (respOk) begin
                fetchPC <= fetchPC + 16'd1;
            end
            if (accept) begin
                headPC <= headPC + pcStep;
            end
            if (iMemValid && drop) begin
                drop <= 1'b0;
            end
        end
    end

    // Outstanding request tracker: set on issue, cleared by any response
    always_ff @(posedge iClock) begin
        if (iReset) begin
            outstanding <= 1'b0;
        end else if (oMemReq) begin
            outstanding <= 1'b1;
        end else if (iMemValid) begin
            outstanding <= 1'b0;
        end
    end

endmodule

// File: tb/tb_embertrail_fetch.sv
// Bench for embertrail_fetch: two instances (RESET_PC 0000 and FFFF) share control inputs,
// each with its own memory responder; accepted packets are scored against a packet stream
// derived from a halfword memory image, plus directed timing checks.
module tb_embertrail_fetch;

    logic              iClock = 1'b0;
    logic              iReset = 1'b1;
    logic              iRedirect = 1'b0;
    logic [15:0]       iTarget = 16'h0;
    logic              iIRReady = 1'b0;
    logic [1:0]        memReq;
    logic [1:0][15:0]  memAddr;
    logic [1:0]        memValid = 2'b00;
    logic [1:0][15:0]  memData = '0;
    logic [1:0]        irValid;
    logic [1:0][31:0]  ir;
    logic [1:0][15:0]  pc;

    always #5 iClock = ~iClock;

    embertrail_fetch #(.DEPTH(4), .RESET_PC(16'h0000)) dutA (
        .iClock(iClock), .iReset(iReset),
        .oMemReq(memReq[0]), .oMemAddr(memAddr[0]),
        .iMemValid(memValid[0]), .iMemData(memData[0]),
        .iRedirect(iRedirect), .iTarget(iTarget),
        .oIRValid(irValid[0]), .iIRReady(iIRReady),
        .oIR(ir[0]), .oPC(pc[0])
    );

    embertrail_fetch #(.DEPTH(4), .RESET_PC(16'hFFFF)) dutB (
        .iClock(iClock), .iReset(iReset),
        .oMemReq(memReq[1]), .oMemAddr(memAddr[1]),
        .iMemValid(memValid[1]), .iMemData(memData[1]),
        .iRedirect(iRedirect), .iTarget(iTarget),
        .oIRValid(irValid[1]), .iIRReady(iIRReady),
        .oIR(ir[1]), .oPC(pc[1])
    );

    // Stimulus controls applied by runCycle
    logic        rst = 1'b1;
    logic        rdy = 1'b0;
    logic        redir = 1'b0;
    logic [15:0] tgt = 16'h0;
    int          fixedLat = 1;

    // Reference model state
    logic [15:0] mem [0:65535];
    logic [15:0] resetPC [2];
    int          pendCnt [2];
    logic [15:0] pendAddr [2];
    int          pendEpoch [2];
    int          epoch = 0;
    logic [15:0] expPC [2];
    logic [15:0] expFetch [2];
    logic        prevStall [2];
    logic [31:0] prevIR [2];
    logic [15:0] prevPC [2];
    int          accepted [2];

    int nCmp = 0;
    int nErr = 0;

    task automatic chk(input int k, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    // Packet starting at address p: one halfword, or two when bit 15 is set
    function automatic logic [31:0] pktIR(input logic [15:0] p);
        logic [15:0] h0;
        logic [15:0] h1;
        logic [15:0] p1;
        p1 = p + 16'd1;
        h0 = mem[p];
        h1 = mem[p1];
        return h0[15] ? {h1, h0} : {16'h0, h0};
    endfunction

    function automatic logic [15:0] pktLen(input logic [15:0] p);
        logic [15:0] h0;
        h0 = mem[p];
        return h0[15] ? 16'd2 : 16'd1;
    endfunction

    // One clock: drive inputs after the edge, sample mid-cycle, score, advance model
    task automatic runCycle();
        @(posedge iClock);
        #1;
        iReset    = rst;
        iIRReady  = rdy;
        iRedirect = redir;
        iTarget   = tgt;
        for (int k = 0; k < 2; k++) begin
            memValid[k] = (pendCnt[k] == 1);
            memData[k]  = (pendCnt[k] == 1) ? mem[pendAddr[k]] : 16'($urandom);
        end
        #3;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                pendCnt[k]   = 0;
                expPC[k]     = resetPC[k];
                expFetch[k]  = resetPC[k];
                prevStall[k] = 1'b0;
            end else begin
                if (memReq[k]) begin
                    chk(k, "req_while_busy", pendCnt[k], 0);
                    chk(k, "req_addr", memAddr[k], expFetch[k]);
                end
                if (redir) chk(k, "req_in_redirect", memReq[k], 0);
                if (prevStall[k]) begin
                    chk(k, "stall_valid", irValid[k], 1);
                    chk(k, "stall_ir", ir[k], prevIR[k]);
                    chk(k, "stall_pc", pc[k], prevPC[k]);
                end
                if (irValid[k] && rdy && !redir) begin
                    chk(k, "pkt_pc", pc[k], expPC[k]);
                    chk(k, "pkt_ir", ir[k], pktIR(expPC[k]));
                    expPC[k] = expPC[k] + pktLen(expPC[k]);
                    accepted[k]++;
                end
                prevStall[k] = irValid[k] && !rdy && !redir;
                prevIR[k]    = ir[k];
                prevPC[k]    = pc[k];
                if (memValid[k] && pendEpoch[k] == epoch && !redir) expFetch[k] = expFetch[k] + 16'd1;
                if (redir) begin
                    expPC[k]    = tgt;
                    expFetch[k] = tgt;
                end
                if (pendCnt[k] > 0) pendCnt[k]--;
                if (memReq[k]) begin
                    pendCnt[k]   = (fixedLat != 0) ? fixedLat : int'($urandom_range(1, 3));
                    pendAddr[k]  = memAddr[k];
                    pendEpoch[k] = redir ? epoch + 1 : epoch;
                end
            end
        end
        if (redir && !rst) epoch++;
    endtask

    initial begin
        bit found;
        resetPC[0] = 16'h0000;
        resetPC[1] = 16'hFFFF;
        for (int k = 0; k < 2; k++) begin
            pendCnt[k] = 0; pendAddr[k] = 16'h0; pendEpoch[k] = 0;
            expPC[k] = resetPC[k]; expFetch[k] = resetPC[k];
            prevStall[k] = 1'b0; prevIR[k] = 32'h0; prevPC[k] = 16'h0; accepted[k] = 0;
        end
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[16'h0000] = 16'h0001;
        mem[16'h0001] = 16'h0012;
        mem[16'h0002] = 16'h0003;
        mem[16'h0003] = 16'h7777;
        mem[16'hFFFF] = 16'h8001;
        mem[16'h0100] = 16'h0005;
        mem[16'h0200] = 16'h800C;
        mem[16'h0201] = 16'h0040;
        mem[16'h0202] = 16'h0003;

        // Reset values
        rst = 1'b1; rdy = 1'b1;
        runCycle();
        runCycle();
        for (int k = 0; k < 2; k++) begin
            chk(k, "rst_memreq", memReq[k], 0);
            chk(k, "rst_memaddr", memAddr[k], resetPC[k]);
            chk(k, "rst_irvalid", irValid[k], 0);
            chk(k, "rst_ir", ir[k], 32'h0);
            chk(k, "rst_pc", pc[k], resetPC[k]);
        end

        // Sequential fetch from reset, 1-cycle memory; B starts with a dual packet at FFFF
        rst = 1'b0; fixedLat = 1;
        runCycle(); // c0
        chk(0, "c0_req", memReq[0], 1);
        chk(0, "c0_addr", memAddr[0], 16'h0000);
        chk(1, "c0_req", memReq[1], 1);
        chk(1, "c0_addr", memAddr[1], 16'hFFFF);
        runCycle(); // c1
`ifdef EMBERTRAIL_FETCH_BYPASS_EN
        chk(0, "c1_bypass_valid", irValid[0], 1);
        chk(0, "c1_bypass_ir", ir[0], 32'h0000_0001);
`else
        chk(0, "c1_valid", irValid[0], 0);
`endif
        chk(1, "c1_valid", irValid[1], 0);
        runCycle(); // c2
`ifdef EMBERTRAIL_FETCH_BYPASS_EN
        chk(0, "c2_valid", irValid[0], 0);
`else
        chk(0, "c2_valid", irValid[0], 1);
        chk(0, "c2_pc", pc[0], 16'h0000);
`endif
        chk(0, "c2_addr", memAddr[0], 16'h0001);
        chk(1, "c2_addr", memAddr[1], 16'h0000);
        chk(1, "c2_half_dual_valid", irValid[1], 0);
        runCycle(); // c3
        runCycle(); // c4
        chk(0, "c4_addr", memAddr[0], 16'h0002);
        chk(1, "c4_addr", memAddr[1], 16'h0001);
        chk(1, "c4_dual_valid", irValid[1], 1);
        chk(1, "c4_dual_ir", ir[1], 32'h0001_8001);
        chk(1, "c4_dual_pc", pc[1], 16'hFFFF);
        runCycle(); // c5
`ifdef EMBERTRAIL_FETCH_BYPASS_EN
        chk(1, "c5_after_wrap_pc", pc[1], 16'h0001);
        chk(1, "c5_after_wrap_valid", irValid[1], 1);
`endif
        fixedLat = 3;
        runCycle(); // c6: long-latency request in flight
`ifndef EMBERTRAIL_FETCH_BYPASS_EN
        chk(1, "c6_after_wrap_pc", pc[1], 16'h0001);
        chk(1, "c6_after_wrap_valid", irValid[1], 1);
`endif
        chk(0, "c6_addr", memAddr[0], 16'h0003);
        chk(0, "c6_req", memReq[0], 1);

        // Redirect with a request outstanding: its response is dropped
        fixedLat = 1; redir = 1'b1; tgt = 16'h0100;
        runCycle(); // c7
        redir = 1'b0;
        runCycle(); // c8
        for (int k = 0; k < 2; k++) chk(k, "c8_req", memReq[k], 0);
        runCycle(); // c9: dropped response
        for (int k = 0; k < 2; k++) chk(k, "c9_req", memReq[k], 0);
        runCycle(); // c10
        for (int k = 0; k < 2; k++) begin
            chk(k, "c10_req", memReq[k], 1);
            chk(k, "c10_addr", memAddr[k], 16'h0100);
        end
        runCycle(); // c11: response 0005 into an empty queue
        for (int k = 0; k < 2; k++) begin
`ifdef EMBERTRAIL_FETCH_BYPASS_EN
            chk(k, "c11_bypass_valid", irValid[k], 1);
            chk(k, "c11_bypass_pc", pc[k], 16'h0100);
            chk(k, "c11_bypass_ir", ir[k], 32'h0000_0005);
`else
            chk(k, "c11_valid", irValid[k], 0);
`endif
        end
        runCycle(); // c12
        for (int k = 0; k < 2; k++) begin
`ifdef EMBERTRAIL_FETCH_BYPASS_EN
            chk(k, "c12_queue_empty", irValid[k], 0);
`else
            chk(k, "c12_valid", irValid[k], 1);
            chk(k, "c12_pc", pc[k], 16'h0100);
            chk(k, "c12_ir", ir[k], 32'h0000_0005);
`endif
        end

        // Long stall: queue saturates, requests stop, output holds
        rdy = 1'b0;
        repeat (20) runCycle();
        for (int k = 0; k < 2; k++) begin
            chk(k, "full_req", memReq[k], 0);
            chk(k, "full_valid", irValid[k], 1);
        end
        rdy = 1'b1;
        repeat (30) runCycle();

        // Refill, then redirect with nothing outstanding to a dual packet at 0200
        rdy = 1'b0;
        repeat (12) runCycle();
        redir = 1'b1; tgt = 16'h0200;
        runCycle(); // R
        redir = 1'b0; rdy = 1'b1;
        runCycle(); // R+1
        for (int k = 0; k < 2; k++) begin
            chk(k, "r1_req", memReq[k], 1);
            chk(k, "r1_addr", memAddr[k], 16'h0200);
        end
        runCycle(); // R+2
        runCycle(); // R+3
        for (int k = 0; k < 2; k++) begin
            chk(k, "r3_half_dual_valid", irValid[k], 0);
            chk(k, "r3_addr", memAddr[k], 16'h0201);
        end
        runCycle(); // R+4
        runCycle(); // R+5
        for (int k = 0; k < 2; k++) begin
            chk(k, "r5_valid", irValid[k], 1);
            chk(k, "r5_ir", ir[k], 32'h0040_800C);
            chk(k, "r5_pc", pc[k], 16'h0200);
        end
        repeat (6) runCycle();

        // Reset landing on a response cycle
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pendCnt[0] == 1) found = 1'b1;
            else runCycle();
        end
        chk(0, "reset_align_found", found, 1);
        rst = 1'b1;
        runCycle();
        runCycle();
        for (int k = 0; k < 2; k++) begin
            chk(k, "rst2_irvalid", irValid[k], 0);
            chk(k, "rst2_pc", pc[k], resetPC[k]);
        end
        rst = 1'b0;
        runCycle();
        for (int k = 0; k < 2; k++) begin
            chk(k, "rst2_first_req", memReq[k], 1);
            chk(k, "rst2_first_addr", memAddr[k], resetPC[k]);
        end

        // Randomized traffic: random memory latency, backpressure and redirects
        fixedLat = 0;
        for (int i = 0; i < 3000; i++) begin
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 30) == 0);
            tgt   = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + 16'($urandom_range(0, 3))) : 16'($urandom);
            runCycle();
        end
        redir = 1'b0;
        rdy   = 1'b1;
        repeat (10) runCycle();
        for (int k = 0; k < 2; k++) chk(k, "liveness", (accepted[k] > 200) ? 1 : 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
